// File: rtl/uart_pkg.sv
// Shared UART definitions: the arbiter FSM state encoding and the byte width
// shared with the transmitter.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [3:0] {
        IDLE      = 4'b0001,
        LAUNCH    = 4'b0010,
        WAIT_DONE = 4'b0100,
        GAP       = 4'b1000
    } state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester fabric and transmitter signals shared by the arbiter.
// The master side drives requests and transmitter status; the slave side is the arbiter.
interface uart_tx_arbiter_if
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = UART_DATA_W
);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic [DATA_W-1:0]         UART_TxREG;
    logic                      UART_STA_TX;
    logic                      tx_busy;
    logic                      tx_done;

    modport master (
        output req_valid, req_data, tx_busy, tx_done,
        input  req_ready, UART_TxREG, UART_STA_TX
    );

    modport slave (
        input  req_valid, req_data, tx_busy, tx_done,
        output req_ready, UART_TxREG, UART_STA_TX
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin priority rotate: the first set request at or above
// ptr, with wrap-around, wins. Returns the winner as a one-hot vector and as an index.
module rr_arbiter #(
    parameter  int N     = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any_req
);

    logic [IDX_W-1:0] cand [N];
    logic             found;

    // cand[k] is the requester examined k steps after the pointer.
    for (genvar k = 0; k < N; k++) begin : g_cand
        assign cand[k] = IDX_W'((int'(ptr) + k) % N);
    end

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && req[cand[k]]) begin
                found           = 1'b1;
                grant[cand[k]]  = 1'b1;
                grant_idx       = cand[k];
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter and sequencer that shares one UART transmitter among
// NUM_REQ byte producers, with inter-frame gap and completion watchdog.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_W         = UART_DATA_W,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                       clk,
    input  logic                       rst_n,
    uart_tx_arbiter_if.slave           bus,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       err_timeout
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GAP_W  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   grant_id_q, grant_id_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [NUM_REQ-1:0] ready_q, ready_d;
    logic               sta_q, sta_d;
    logic               err_q, err_d;
    logic [WDOG_W-1:0]  wdog_q, wdog_d;
    logic [GAP_W-1:0]   gap_q, gap_d;

    logic [NUM_REQ-1:0] arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic               any_req;
    logic               wdog_hit;
    logic [DATA_W-1:0]  req_bytes [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_bytes
        assign req_bytes[i] = bus.req_data[i*DATA_W +: DATA_W];
    end

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req       (bus.req_valid),
        .ptr       (ptr_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any_req   (any_req)
    );

    assign wdog_hit = (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_id_d = grant_id_q;
        data_d     = data_q;
        ready_d    = '0;
        sta_d      = sta_q;
        err_d      = 1'b0;
        wdog_d     = wdog_q;
        gap_d      = gap_q;

        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_id_d = arb_idx;
                    data_d     = req_bytes[arb_idx];
                    ready_d    = arb_grant;
                    sta_d      = 1'b1;
                    wdog_d     = '0;
                    ptr_d      = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);
                    state_d    = LAUNCH;
                end
            end
            LAUNCH: begin
                // A same-edge busy+done is a frame that started and finished at once.
                if (bus.tx_busy) begin
                    sta_d  = 1'b0;
                    wdog_d = '0;
                    if (!bus.tx_done) begin
                        state_d = WAIT_DONE;
                    end else if (GAP_CYCLES == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = GAP;
                        gap_d   = GAP_W'(GAP_CYCLES);
                    end
                end else if (wdog_hit) begin
                    sta_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wdog_d = wdog_q + WDOG_W'(1);
                end
            end
            WAIT_DONE: begin
                if (bus.tx_done) begin
                    if (GAP_CYCLES == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = GAP;
                        gap_d   = GAP_W'(GAP_CYCLES);
                    end
                end else if (wdog_hit) begin
                    sta_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wdog_d = wdog_q + WDOG_W'(1);
                end
            end
            GAP: begin
                if (gap_q <= GAP_W'(1)) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            grant_id_q <= '0;
            data_q     <= '0;
            ready_q    <= '0;
            sta_q      <= 1'b0;
            err_q      <= 1'b0;
            wdog_q     <= '0;
            gap_q      <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_id_q <= grant_id_d;
            data_q     <= data_d;
            ready_q    <= ready_d;
            sta_q      <= sta_d;
            err_q      <= err_d;
            wdog_q     <= wdog_d;
            gap_q      <= gap_d;
        end
    end

    assign bus.req_ready   = ready_q;
    assign bus.UART_TxREG  = data_q;
    assign bus.UART_STA_TX = sta_q;
    assign grant_id        = grant_id_q;
    assign err_timeout     = err_q;
    assign busy            = (state_q != IDLE);

endmodule
